// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter sequencer: flag bit positions,
// PC increment, reset PC and the strobe priority order (lowest index wins).
package cpu_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    localparam int PC_INC      = 4;
    localparam int NUM_STROBES = 12;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Declaration order is the arbitration order: S_RET beats everything.
    typedef enum logic [3:0] {
        S_RET, S_CALL, S_BR, S_B,
        S_BZ, S_BNZ, S_BCY, S_BNCY,
        S_BS, S_BNS, S_BV, S_BNV
    } strobe_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/ALU-to-sequencer bundle. master = decode/execute side, slave = sequencer.
interface pc_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 22
);
    logic             stall;
    logic             b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  reg_target;
    logic             flag_we;
    logic             alu_z, alu_c, alu_s, alu_v;
    logic [PC_W-1:0]  pc;
    logic [3:0]       flags;
    logic             taken;
    logic             flush;
    logic             ras_ovf;
    logic             ras_unf;
    logic             multi_err;

    modport master (
        output stall, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret,
        output offset, reg_target, flag_we, alu_z, alu_c, alu_s, alu_v,
        input  pc, flags, taken, flush, ras_ovf, ras_unf, multi_err
    );

    modport slave (
        input  stall, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret,
        input  offset, reg_target, flag_we, alu_z, alu_c, alu_s, alu_v,
        output pc, flags, taken, flush, ras_ovf, ras_unf, multi_err
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    // ptr_q is the next write slot, so the newest entry sits one below it.
    assign top   = mem_q[ptr_q - AW'(1)];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + AW'(1);
            if (!full) cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - AW'(1);
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: arbitrates decoder strobes, evaluates branch conditions on
// the registered flags, and keeps the PC, flag register and return-address stack.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              OFF_W     = 22,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
);
    logic [NUM_STROBES-1:0] stb;
    strobe_e                win;
    logic                   any, multi, cond, taken;
    logic [PC_W-1:0]        seq_pc, rel_target, target;
    logic                   ras_push, ras_pop, ras_empty, ras_full;
    logic [PC_W-1:0]        ras_top;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic            flush_q, flush_d;
    logic            ras_ovf_q, ras_ovf_d;
    logic            ras_unf_q, ras_unf_d;
    logic            multi_err_q, multi_err_d;

    assign stb = {bus.bnv, bus.bv, bus.bns, bus.bs, bus.bncy, bus.bcy,
                  bus.bnz, bus.bz, bus.b, bus.br, bus.call, bus.ret};

    assign seq_pc     = pc_q + PC_W'(PC_INC);
    assign rel_target = pc_q + {{(PC_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};

    always_comb begin
        win = S_BNV;
        any = 1'b0;
        // Scan from lowest priority upward so the highest-priority strobe is left in win.
        for (int i = NUM_STROBES - 1; i >= 0; i--) begin
            if (stb[i]) begin
                win = strobe_e'(4'(i));
                any = 1'b1;
            end
        end
        multi = ($countones(stb) > 1);

        case (win)
            S_RET:   cond = !ras_empty;
            S_BZ:    cond =  flags_q[FLAG_Z];
            S_BNZ:   cond = !flags_q[FLAG_Z];
            S_BCY:   cond =  flags_q[FLAG_C];
            S_BNCY:  cond = !flags_q[FLAG_C];
            S_BS:    cond =  flags_q[FLAG_S];
            S_BNS:   cond = !flags_q[FLAG_S];
            S_BV:    cond =  flags_q[FLAG_V];
            S_BNV:   cond = !flags_q[FLAG_V];
            default: cond = 1'b1;
        endcase
        taken = any && cond && !bus.stall;

        case (win)
            S_RET:   target = ras_top;
            S_BR:    target = bus.reg_target;
            default: target = rel_target;
        endcase

        ras_push = any && !bus.stall && (win == S_CALL);
        ras_pop  = taken && (win == S_RET);

        pc_d        = pc_q;
        flags_d     = flags_q;
        flush_d     = flush_q;
        ras_ovf_d   = ras_ovf_q;
        ras_unf_d   = ras_unf_q;
        multi_err_d = multi_err_q;
        if (!bus.stall) begin
            pc_d    = taken ? target : seq_pc;
            flush_d = taken;
            if (bus.flag_we) flags_d = {bus.alu_v, bus.alu_s, bus.alu_c, bus.alu_z};
            if (ras_push && ras_full) ras_ovf_d = 1'b1;
            if (any && win == S_RET && ras_empty) ras_unf_d = 1'b1;
            if (multi) multi_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            flags_q     <= '0;
            flush_q     <= 1'b0;
            ras_ovf_q   <= 1'b0;
            ras_unf_q   <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            flush_q     <= flush_d;
            ras_ovf_q   <= ras_ovf_d;
            ras_unf_q   <= ras_unf_d;
            multi_err_q <= multi_err_d;
        end
    end

    ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign bus.pc        = pc_q;
    assign bus.flags     = flags_q;
    assign bus.taken     = taken;
    assign bus.flush     = flush_q;
    assign bus.ras_ovf   = ras_ovf_q;
    assign bus.ras_unf   = ras_unf_q;
    assign bus.multi_err = multi_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam int T_RET = 0, T_CALL = 1, T_BR = 2, T_B = 3, T_BZ = 4, T_BNZ = 5;
    localparam int T_BCY = 6, T_BNCY = 7, T_BS = 8, T_BNS = 9, T_BV = 10, T_BNV = 11;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.PC_W(32), .OFF_W(22)) bus ();

    pc_sequencer #(.PC_W(32), .OFF_W(22), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [3:0]  m_flags;
    logic        m_flush, m_ovf, m_unf, m_multi;
    logic [31:0] exp_ras_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] one(input int i);
        logic [11:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_flags = 4'h0; m_flush = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_multi = 1'b0;
        exp_ras_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"},        bus.pc,              m_pc);
        check({tag, ".flags"},     32'(bus.flags),      32'(m_flags));
        check({tag, ".flush"},     32'(bus.flush),      32'(m_flush));
        check({tag, ".ras_ovf"},   32'(bus.ras_ovf),    32'(m_ovf));
        check({tag, ".ras_unf"},   32'(bus.ras_unf),    32'(m_unf));
        check({tag, ".multi_err"}, 32'(bus.multi_err),  32'(m_multi));
    endtask

    task automatic drive_idle();
        {bus.ret, bus.call, bus.br, bus.b, bus.bz, bus.bnz} = '0;
        {bus.bcy, bus.bncy, bus.bs, bus.bns, bus.bv, bus.bnv} = '0;
        bus.offset = '0; bus.reg_target = '0; bus.flag_we = 1'b0;
        {bus.alu_v, bus.alu_s, bus.alu_c, bus.alu_z} = 4'h0;
        bus.stall = 1'b0;
    endtask

    // Entered and left at posedge+1. alu is {v,s,c,z}.
    task automatic cycle(input string tag, input logic [11:0] s, input logic [21:0] off,
                         input logic [31:0] tgt, input logic fwe, input logic [3:0] alu,
                         input logic stl);
        int w, n;
        logic tk;
        logic [31:0] tg, sx;
        bus.ret = s[T_RET];   bus.call = s[T_CALL]; bus.br = s[T_BR];   bus.b = s[T_B];
        bus.bz = s[T_BZ];     bus.bnz = s[T_BNZ];   bus.bcy = s[T_BCY]; bus.bncy = s[T_BNCY];
        bus.bs = s[T_BS];     bus.bns = s[T_BNS];   bus.bv = s[T_BV];   bus.bnv = s[T_BNV];
        bus.offset = off; bus.reg_target = tgt; bus.flag_we = fwe;
        {bus.alu_v, bus.alu_s, bus.alu_c, bus.alu_z} = alu;
        bus.stall = stl;

        sx = {{10{off[21]}}, off};
        w = -1; n = 0;
        for (int i = 0; i < 12; i++) if (s[i]) begin n++; if (w < 0) w = i; end
        tk = 1'b0;
        tg = m_pc + sx;
        if (w >= 0) begin
            case (w)
                T_RET:  begin tk = (exp_ras_q.size() > 0); if (tk) tg = exp_ras_q[$]; end
                T_BR:   begin tk = 1'b1; tg = tgt; end
                T_CALL, T_B: tk = 1'b1;
                T_BZ:   tk =  m_flags[0];
                T_BNZ:  tk = !m_flags[0];
                T_BCY:  tk =  m_flags[1];
                T_BNCY: tk = !m_flags[1];
                T_BS:   tk =  m_flags[2];
                T_BNS:  tk = !m_flags[2];
                T_BV:   tk =  m_flags[3];
                default: tk = !m_flags[3];
            endcase
        end
        if (stl) tk = 1'b0;

        #2;
        check({tag, ".taken"}, 32'(bus.taken), 32'(tk));
        @(posedge clk);
        #1;

        if (!stl) begin
            if (w == T_RET && exp_ras_q.size() == 0) m_unf = 1'b1;
            if (w == T_RET && tk) void'(exp_ras_q.pop_back());
            if (w == T_CALL) begin
                if (exp_ras_q.size() == DEPTH) m_ovf = 1'b1;
                exp_ras_q.push_back(m_pc + 32'd4);
                if (exp_ras_q.size() > DEPTH) void'(exp_ras_q.pop_front());
            end
            if (n > 1) m_multi = 1'b1;
            if (fwe) m_flags = alu;
            m_pc    = tk ? tg : m_pc + 32'd4;
            m_flush = tk;
        end
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 12'h0, 22'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    endtask

    // Reset is asserted away from the clock edge and released at posedge+1.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state({tag, ".async"});
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] s;
        logic [21:0] off;
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        check_state("por");
        rst_n = 1'b1;

        // Free-running fetch after reset.
        idle("seq0"); check("seq0.const", bus.pc, 32'h4);
        idle("seq1"); check("seq1.const", bus.pc, 32'h8);
        idle("seq2"); check("seq2.const", bus.pc, 32'hC);

        // Move to 0x100, set Z, then bz/bnz with a negative offset.
        cycle("br100", one(T_BR), 22'h0, 32'h100, 1'b0, 4'h0, 1'b0);
        check("br100.const", bus.pc, 32'h100);
        cycle("setz", 12'h0, 22'h0, 32'h0, 1'b1, 4'b0001, 1'b0);
        cycle("bz_t", one(T_BZ), -22'sd16, 32'h0, 1'b0, 4'h0, 1'b0);
        check("bz_t.const", bus.pc, 32'hF4);
        idle("bz_flush");
        cycle("bnz_nt", one(T_BNZ), -22'sd16, 32'h0, 1'b0, 4'h0, 1'b0);

        // Same-cycle flag write must not affect this cycle's condition.
        cycle("clrz", 12'h0, 22'h0, 32'h0, 1'b1, 4'b0000, 1'b0);
        cycle("bz_same", one(T_BZ), 22'h40, 32'h0, 1'b1, 4'b0001, 1'b0);
        cycle("bz_next", one(T_BZ), 22'h40, 32'h0, 1'b0, 4'h0, 1'b0);

        // Nested call/return from 0x10.
        do_reset("rst_a");
        repeat (4) idle("to10");
        cycle("call1", one(T_CALL), 22'h40, 32'h0, 1'b0, 4'h0, 1'b0);
        check("call1.const", bus.pc, 32'h50);
        cycle("call2", one(T_CALL), 22'h20, 32'h0, 1'b0, 4'h0, 1'b0);
        check("call2.const", bus.pc, 32'h70);
        cycle("ret1", one(T_RET), 22'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        check("ret1.const", bus.pc, 32'h54);
        cycle("ret2", one(T_RET), 22'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        check("ret2.const", bus.pc, 32'h14);

        // Overflow the stack, then drain it past empty.
        do_reset("rst_b");
        repeat (9) cycle("call9", one(T_CALL), 22'h100, 32'h0, 1'b0, 4'h0, 1'b0);
        check("ovf.const", 32'(bus.ras_ovf), 32'h1);
        repeat (8) cycle("ret8", one(T_RET), 22'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        cycle("ret_empty", one(T_RET), 22'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        check("unf.const", 32'(bus.ras_unf), 32'h1);

        // Stall during a taken bz, with a flag write that must be ignored.
        cycle("setz2", 12'h0, 22'h0, 32'h0, 1'b1, 4'b0001, 1'b0);
        repeat (3) cycle("stall", one(T_BZ), 22'h80, 32'h0, 1'b1, 4'b1110, 1'b1);
        cycle("unstall", one(T_BZ), 22'h80, 32'h0, 1'b0, 4'h0, 1'b0);

        // call and br together: call wins.
        cycle("multi", one(T_CALL) | one(T_BR), 22'h20, 32'h4000, 1'b0, 4'h0, 1'b0);
        check("multi.const", 32'(bus.multi_err), 32'h1);

        do_reset("rst_mid");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    s = 12'h0;
                2:       s = one($urandom_range(0, 11)) | one($urandom_range(0, 11));
                3:       s = one(T_RET);
                default: s = one($urandom_range(0, 11));
            endcase
            off = 22'($urandom_range(0, 4096)) - 22'd2048;
            cycle("rand", s, off, $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
            if (k == 200) do_reset("rst_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
